uart_tx_core: RTL and testbench

Parametrised UART transmitter and successor to the single-byte bclk-driven transmitter. It generates its own baud tick from clk and takes data over a valid/ready handshake. A holding register (THR) in front of the shift register (TSR) allows back-to-back frames with no idle gap. Data width, parity mode and stop-bit count are set by parameters. It sits between the bus-side controller and the txd pad.

---
 rtl/uart_tx_core.sv | 145 ++++++++++++++
 tb/tb_uart_tx_core.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_core.sv
// uart_tx_core: parametrised UART transmitter with its own baud divider and a
// one-word holding register so consecutive frames leave the pad with no idle gap.
module uart_tx_core #(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1,
   parameter int CLK_DIV   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] din,
   input  logic                 din_valid,
   output logic                 din_ready,
   output logic                 txd,
   output logic                 busy,
   output logic                 tx_done
);
   localparam int BAUD_W = $clog2(CLK_DIV);
   localparam int BIT_W  = $clog2(DATA_BITS);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
   localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLK_DIV - 2);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
   localparam logic              STOP_LAST = 1'(STOP_BITS - 1);
   localparam logic              ODD_PAR   = (PARITY == 2);

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_core: DATA_BITS must be 5..9");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_core: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_core: STOP_BITS must be 1 or 2");
   end
   if (CLK_DIV < 2) begin : g_bad_clk_div
      $error("uart_tx_core: CLK_DIV must be >= 2");
   end

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t               state;
   logic [DATA_BITS-1:0] thr;
   logic                 thr_full;
   logic [DATA_BITS-1:0] tsr;
   logic                 parity_bit;
   logic [BAUD_W-1:0]    baud_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic                 stop_cnt;
   logic                 tick;

   assign tick      = (baud_cnt == BAUD_LAST);
   assign din_ready = !thr_full;

   // tx_done is raised one edge early so it is high during the final stop-bit clock.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         txd        <= 1'b1;
         busy       <= 1'b0;
         tx_done    <= 1'b0;
         thr        <= '0;
         thr_full   <= 1'b0;
         tsr        <= '0;
         parity_bit <= 1'b0;
         baud_cnt   <= '0;
         bit_cnt    <= '0;
         stop_cnt   <= 1'b0;
      end else begin
         tx_done <= (state == S_STOP) && (stop_cnt == STOP_LAST) && (baud_cnt == BAUD_PRE);
         if (din_valid && !thr_full) begin
            thr      <= din;
            thr_full <= 1'b1;
         end
         if (state != S_IDLE) begin
            baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
         end
         case (state)
            S_IDLE: begin
               if (thr_full) begin
                  tsr        <= thr;
                  parity_bit <= (^thr) ^ ODD_PAR;
                  thr_full   <= 1'b0;
                  baud_cnt   <= '0;
                  state      <= S_START;
                  txd        <= 1'b0;
                  busy       <= 1'b1;
               end
            end
            S_START: begin
               if (tick) begin
                  state   <= S_DATA;
                  txd     <= tsr[0];
                  tsr     <= tsr >> 1;
                  bit_cnt <= '0;
               end
            end
            S_DATA: begin
               if (tick) begin
                  if (bit_cnt == BIT_LAST) begin
                     if (PARITY != 0) begin
                        state <= S_PARITY;
                        txd   <= parity_bit;
                     end else begin
                        state    <= S_STOP;
                        txd      <= 1'b1;
                        stop_cnt <= 1'b0;
                     end
                  end else begin
                     txd     <= tsr[0];
                     tsr     <= tsr >> 1;
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            S_PARITY: begin
               if (tick) begin
                  state    <= S_STOP;
                  txd      <= 1'b1;
                  stop_cnt <= 1'b0;
               end
            end
            S_STOP: begin
               if (tick) begin
                  if (stop_cnt == STOP_LAST) begin
                     if (thr_full) begin
                        tsr        <= thr;
                        parity_bit <= (^thr) ^ ODD_PAR;
                        thr_full   <= 1'b0;
                        baud_cnt   <= '0;
                        state      <= S_START;
                        txd        <= 1'b0;
                     end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                     end
                  end else begin
                     stop_cnt <= stop_cnt + 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: directed bench for uart_tx_core, four instances covering
// no/even/odd parity and a 5-bit, two-stop-bit configuration.
module tb_uart_tx_core;
   localparam int DIV = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [3:0][8:0] din;
   logic [3:0]      din_valid;
   logic [3:0]      din_ready;
   logic [3:0]      txd;
   logic [3:0]      busy;
   logic [3:0]      tx_done;
   int              checks = 0;
   int              errors = 0;

   always #5 clk = ~clk;

   uart_tx_core #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLK_DIV(DIV)) dut_plain (
      .clk(clk), .rst(rst), .din(din[0][7:0]), .din_valid(din_valid[0]),
      .din_ready(din_ready[0]), .txd(txd[0]), .busy(busy[0]), .tx_done(tx_done[0]));

   uart_tx_core #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .CLK_DIV(DIV)) dut_even (
      .clk(clk), .rst(rst), .din(din[1][7:0]), .din_valid(din_valid[1]),
      .din_ready(din_ready[1]), .txd(txd[1]), .busy(busy[1]), .tx_done(tx_done[1]));

   uart_tx_core #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .CLK_DIV(DIV)) dut_odd (
      .clk(clk), .rst(rst), .din(din[2][7:0]), .din_valid(din_valid[2]),
      .din_ready(din_ready[2]), .txd(txd[2]), .busy(busy[2]), .tx_done(tx_done[2]));

   uart_tx_core #(.DATA_BITS(5), .PARITY(0), .STOP_BITS(2), .CLK_DIV(DIV)) dut_short (
      .clk(clk), .rst(rst), .din(din[3][4:0]), .din_valid(din_valid[3]),
      .din_ready(din_ready[3]), .txd(txd[3]), .busy(busy[3]), .tx_done(tx_done[3]));

   task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one word and return just after the edge that accepted it.
   task automatic apply_stimulus(input int idx, input logic [8:0] data);
      int waited = 0;
      din[idx]       = data;
      din_valid[idx] = 1'b1;
      while (!din_ready[idx] && waited < 200) begin
         step();
         waited++;
      end
      check_output("accept_ready", 32'(din_ready[idx]), 32'd1);
      step();
      din_valid[idx] = 1'b0;
   endtask

   // bits[i] is the i-th bit on the line, start bit first.
   task automatic check_frame(input int idx, input logic [15:0] bits, input int nbits,
                              input bit check_ready, input bit last_frame);
      for (int i = 0; i < nbits; i++) begin
         for (int j = 0; j < DIV; j++) begin
            step();
            check_output($sformatf("txd_dut%0d_bit%0d", idx, i), 32'(txd[idx]), 32'(bits[i]));
            check_output($sformatf("tx_done_dut%0d_bit%0d", idx, i), 32'(tx_done[idx]),
                         32'((i == nbits - 1) && (j == DIV - 1)));
            check_output($sformatf("busy_dut%0d_bit%0d", idx, i), 32'(busy[idx]), 32'd1);
            if (check_ready) begin
               check_output($sformatf("din_ready_dut%0d_bit%0d", idx, i), 32'(din_ready[idx]), 32'd1);
            end
         end
      end
      if (last_frame) begin
         step();
         check_output("idle_busy", 32'(busy[idx]), 32'd0);
         check_output("idle_txd", 32'(txd[idx]), 32'd1);
         check_output("idle_tx_done", 32'(tx_done[idx]), 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst       = 1'b0;
      din       = '0;
      din_valid = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         check_output($sformatf("reset_txd%0d", k), 32'(txd[k]), 32'd1);
         check_output($sformatf("reset_busy%0d", k), 32'(busy[k]), 32'd0);
         check_output($sformatf("reset_ready%0d", k), 32'(din_ready[k]), 32'd1);
         check_output($sformatf("reset_done%0d", k), 32'(tx_done[k]), 32'd0);
      end
      rst = 1'b1;
      step();

      // 0xA5, 8N1: 0,1,0,1,0,0,1,0,1,1
      apply_stimulus(0, 9'h0A5);
      check_output("pre_start_txd", 32'(txd[0]), 32'd1);
      check_output("accept_ready_low", 32'(din_ready[0]), 32'd0);
      check_frame(0, 16'h034A, 10, 1'b1, 1'b1);

      // 0x07 with even parity (bit 1) and odd parity (bit 0)
      apply_stimulus(1, 9'h007);
      check_output("even_pre_start", 32'(txd[1]), 32'd1);
      check_frame(1, 16'h060E, 11, 1'b1, 1'b1);
      apply_stimulus(2, 9'h007);
      check_output("odd_pre_start", 32'(txd[2]), 32'd1);
      check_frame(2, 16'h040E, 11, 1'b1, 1'b1);

      // 5 data bits, 2 stop bits, upper din bits dropped: 0,1,1,0,0,1,1,1
      apply_stimulus(3, 9'h1F3);
      check_output("short_pre_start", 32'(txd[3]), 32'd1);
      check_frame(3, 16'h00E6, 8, 1'b1, 1'b1);

      // Back-to-back 0x55 then 0x0F; din wiggles while THR is full.
      apply_stimulus(0, 9'h055);
      fork
         check_frame(0, 16'h02AA, 10, 1'b0, 1'b0);
         begin
            repeat (12) step();
            check_output("b2b_ready_mid", 32'(din_ready[0]), 32'd1);
            din[0]       = 9'h00F;
            din_valid[0] = 1'b1;
            step();
            for (int k = 0; k < 27; k++) begin
               din[0] = 9'(8'hF0 ^ k);
               check_output($sformatf("b2b_ready_held%0d", k), 32'(din_ready[0]), 32'd0);
               step();
            end
            check_output("b2b_ready_at_done", 32'(din_ready[0]), 32'd0);
            din_valid[0] = 1'b0;
         end
      join
      check_frame(0, 16'h021E, 10, 1'b1, 1'b1);

      // Async reset mid-DATA with THR full discards everything.
      apply_stimulus(0, 9'h0C3);
      repeat (10) step();
      din[0]       = 9'h03C;
      din_valid[0] = 1'b1;
      step();
      din_valid[0] = 1'b0;
      check_output("rst_thr_full", 32'(din_ready[0]), 32'd0);
      check_output("rst_mid_frame_busy", 32'(busy[0]), 32'd1);
      step();
      #2;
      rst = 1'b0;
      #1;
      check_output("rst_async_txd", 32'(txd[0]), 32'd1);
      check_output("rst_async_busy", 32'(busy[0]), 32'd0);
      check_output("rst_async_ready", 32'(din_ready[0]), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 60; k++) begin
         step();
         check_output($sformatf("post_rst_txd%0d", k), 32'(txd[0]), 32'd1);
         check_output($sformatf("post_rst_busy%0d", k), 32'(busy[0]), 32'd0);
      end
      check_output("post_rst_ready", 32'(din_ready[0]), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
